regfile_write_init_seq: RTL and testbench

- Write-port front end that sits directly upstream of the multi-port register file; drives its WRITE_EN_WRITE / WRITE_INDEX_WRITE / WRITE_DATA_WRITE inputs.
- After reset, or on request, sweeps every entry with a fill pattern.
- Once the sweep completes, forwards client writes with a valid/ready handshake and raises DONE.
- Gives the register file deterministic contents without file loading, and gives consumers a clear "array ready" indication.

---
 rtl/regfile_write_init_seq.sv | 164 ++++++++++++++++
 tb/tb_regfile_write_init_seq.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_init_seq.sv
// regfile_write_init_seq
// ----------------------
// Write-port front end for the multi-port register file. After reset, or when
// START is pulsed while running, it sweeps every entry with a fill pattern on
// consecutive cycles. Once the sweep has been committed it forwards client
// writes (valid/ready handshake, one cycle of latency) and raises DONE.
//
// Parameters:
//   width      - data width in bits
//   n          - index width in bits (0 means a single-entry file)
//   size       - number of entries, 1..2^n
//   fill_value - constant written by a sweep when fill_mode == 0
//   fill_mode  - 0: write fill_value, 1: write the entry index resized to width
//
// Ports:
//   CLK               - clock, rising edge
//   RST               - asynchronous active-high reset
//   START             - single-cycle request to re-run the sweep (ignored while filling)
//   CLIENT_WR_EN      - client write valid
//   CLIENT_WR_INDEX   - client write index
//   CLIENT_WR_DATA    - client write data
//   CLIENT_WR_READY   - client write accepted when EN && READY (combinational)
//   WRITE_EN_WRITE    - registered write enable to the register file
//   WRITE_INDEX_WRITE - registered write index to the register file
//   WRITE_DATA_WRITE  - registered write data to the register file
//   DONE              - register file initialised and accepting client writes
//   BUSY              - fill sweep in progress

module regfile_write_init_seq #(
   parameter int width = 32,
   parameter int n     = 5,
   parameter int size  = 32,
   parameter logic [((width > 0) ? width : 1)-1:0] fill_value = '0,
   parameter int fill_mode = 0
) (
   input  logic                                 CLK,
   input  logic                                 RST,
   input  logic                                 START,
   input  logic                                 CLIENT_WR_EN,
   input  logic [((n > 0) ? n : 1)-1:0]         CLIENT_WR_INDEX,
   input  logic [((width > 0) ? width : 1)-1:0] CLIENT_WR_DATA,
   output logic                                 CLIENT_WR_READY,
   output logic                                 WRITE_EN_WRITE,
   output logic [((n > 0) ? n : 1)-1:0]         WRITE_INDEX_WRITE,
   output logic [((width > 0) ? width : 1)-1:0] WRITE_DATA_WRITE,
   output logic                                 DONE,
   output logic                                 BUSY
);

   localparam int IW = (n > 0) ? n : 1;
   localparam int DW = (width > 0) ? width : 1;
   localparam int CW = n + 1;

   // Sweep counter value of the final entry; size <= 2^n always fits in n+1 bits.
   localparam logic [CW-1:0] LAST_CNT = CW'(size - 1);

   typedef enum logic {
      FILL = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            we_q, we_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [DW-1:0]   data_q, data_d;
   logic            done_q, done_d;
   logic            busy_q, busy_d;

   logic [IW-1:0]   cnt_index;
   logic [IW-1:0]   client_index;
   logic [DW-1:0]   fill_data;
   logic            client_accept;

   // Zero-extends or truncates the sweep counter to the data width.
   function automatic logic [DW-1:0] resize_cnt(input logic [CW-1:0] c);
      logic [DW-1:0] r;
      r = '0;
      for (int i = 0; (i < DW) && (i < CW); i++) begin
         r[i] = c[i];
      end
      return r;
   endfunction

   // A single-entry file has no meaningful index bits, so the index is tied to zero.
   assign cnt_index    = (n == 0) ? '0 : cnt_q[IW-1:0];
   assign client_index = (n == 0) ? '0 : CLIENT_WR_INDEX;
   assign fill_data    = (fill_mode != 0) ? resize_cnt(cnt_q) : fill_value;

   // READY waits for DONE so that no client write can race the last fill write,
   // and drops with START so a restart never swallows a write silently.
   assign CLIENT_WR_READY = (state_q == RUN) && done_q && !START;
   assign client_accept   = CLIENT_WR_EN && CLIENT_WR_READY;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = 1'b0;
      idx_d   = idx_q;
      data_d  = data_q;
      done_d  = done_q;
      busy_d  = busy_q;

      case (state_q)
         FILL: begin
            we_d   = 1'b1;
            idx_d  = cnt_index;
            data_d = fill_data;
            done_d = 1'b0;
            busy_d = 1'b1;
            if (cnt_q == LAST_CNT) begin
               state_d = RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         RUN: begin
            if (START) begin
               state_d = FILL;
               cnt_d   = '0;
               done_d  = 1'b0;
               busy_d  = 1'b1;
            end else begin
               // The first RUN edge is the one on which the last fill write commits.
               done_d = 1'b1;
               busy_d = 1'b0;
               if (client_accept) begin
                  we_d   = 1'b1;
                  idx_d  = client_index;
                  data_d = CLIENT_WR_DATA;
               end
            end
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= FILL;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         idx_q   <= '0;
         data_q  <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   assign WRITE_EN_WRITE    = we_q;
   assign WRITE_INDEX_WRITE = idx_q;
   assign WRITE_DATA_WRITE  = data_q;
   assign DONE              = done_q;
   assign BUSY              = busy_q;

endmodule

// File: tb/tb_regfile_write_init_seq.sv
// Testbench for regfile_write_init_seq. Three instances share one clock:
// the default configuration (driven through all phases), a fill_mode=1 /
// size=20 instance and an n=0 / size=1 instance with a non-zero fill value.
// Expected register-file writes are queued when stimulus is issued; a monitor
// pops and compares them whenever an instance presents WRITE_EN_WRITE.

module tb_regfile_write_init_seq;

   typedef struct packed {
      logic [4:0]  idx;
      logic [31:0] data;
   } wr_t;

   logic        clk;
   logic        rst;
   logic        rst_aux;

   // Default instance signals
   logic        start;
   logic        wr_en;
   logic [4:0]  wr_idx;
   logic [31:0] wr_data;
   logic        ready;
   logic        we;
   logic [4:0]  idx;
   logic [31:0] data;
   logic        done;
   logic        busy;

   // fill_mode=1, size=20 instance signals
   logic        start_fm;
   logic        wr_en_fm;
   logic [4:0]  wr_idx_fm;
   logic [31:0] wr_data_fm;
   logic        ready_fm;
   logic        we_fm;
   logic [4:0]  idx_fm;
   logic [31:0] data_fm;
   logic        done_fm;
   logic        busy_fm;

   // n=0, size=1 instance signals
   logic        start_n0;
   logic        wr_en_n0;
   logic [0:0]  wr_idx_n0;
   logic [31:0] wr_data_n0;
   logic        ready_n0;
   logic        we_n0;
   logic [0:0]  idx_n0;
   logic [31:0] data_n0;
   logic        done_n0;
   logic        busy_n0;

   wr_t         q_main[$];
   wr_t         q_fm[$];
   wr_t         q_n0[$];
   logic [31:0] mem[32];

   int          checks = 0;
   int          errors = 0;

   regfile_write_init_seq dut (
      .CLK(clk), .RST(rst), .START(start),
      .CLIENT_WR_EN(wr_en), .CLIENT_WR_INDEX(wr_idx), .CLIENT_WR_DATA(wr_data),
      .CLIENT_WR_READY(ready), .WRITE_EN_WRITE(we), .WRITE_INDEX_WRITE(idx),
      .WRITE_DATA_WRITE(data), .DONE(done), .BUSY(busy)
   );

   regfile_write_init_seq #(.fill_mode(1), .size(20)) dut_fm (
      .CLK(clk), .RST(rst_aux), .START(start_fm),
      .CLIENT_WR_EN(wr_en_fm), .CLIENT_WR_INDEX(wr_idx_fm), .CLIENT_WR_DATA(wr_data_fm),
      .CLIENT_WR_READY(ready_fm), .WRITE_EN_WRITE(we_fm), .WRITE_INDEX_WRITE(idx_fm),
      .WRITE_DATA_WRITE(data_fm), .DONE(done_fm), .BUSY(busy_fm)
   );

   regfile_write_init_seq #(.n(0), .size(1), .fill_value(32'hA5A5_0001)) dut_n0 (
      .CLK(clk), .RST(rst_aux), .START(start_n0),
      .CLIENT_WR_EN(wr_en_n0), .CLIENT_WR_INDEX(wr_idx_n0), .CLIENT_WR_DATA(wr_data_n0),
      .CLIENT_WR_READY(ready_n0), .WRITE_EN_WRITE(we_n0), .WRITE_INDEX_WRITE(idx_n0),
      .WRITE_DATA_WRITE(data_n0), .DONE(done_n0), .BUSY(busy_n0)
   );

   // Free-running clock, period 10
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Safety net so the run always ends
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Compares one value against its hand-computed expectation
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Drives the default instance's client inputs; queues the write when it should be accepted
   task automatic applyStimulus(input logic en, input logic [4:0] i, input logic [31:0] d,
                                input logic st, input logic expect_accept);
      wr_t e;
      wr_en   = en;
      wr_idx  = i;
      wr_data = d;
      start   = st;
      if (en && expect_accept) begin
         e.idx  = i;
         e.data = d;
         q_main.push_back(e);
      end
      if (en) begin
         #1;
         checkOutput("client_ready", {31'b0, ready}, {31'b0, expect_accept});
      end
   endtask

   // Queues a full or partial default-instance sweep of zeros
   task automatic pushMainFill(input int count);
      wr_t e;
      for (int i = 0; i < count; i++) begin
         e.idx  = 5'(i);
         e.data = 32'h0;
         q_main.push_back(e);
      end
   endtask

   // Scoreboard monitor: sampled on the falling edge, away from the active edge
   always @(negedge clk) begin
      wr_t e;
      if (we) begin
         checks++;
         if (q_main.size() == 0) begin
            errors++;
            $display("[TB] FAIL main_write: got unexpected write idx=%0d data=%0h, expected none", idx, data);
         end else begin
            e = q_main.pop_front();
            if (idx !== e.idx || data !== e.data) begin
               errors++;
               $display("[TB] FAIL main_write: got idx=%0d data=%0h, expected idx=%0d data=%0h",
                        idx, data, e.idx, e.data);
            end
         end
         mem[idx] = data;
      end
      if (we_fm) begin
         checks++;
         if (q_fm.size() == 0) begin
            errors++;
            $display("[TB] FAIL fm_write: got unexpected write idx=%0d data=%0h, expected none", idx_fm, data_fm);
         end else begin
            e = q_fm.pop_front();
            if (idx_fm !== e.idx || data_fm !== e.data) begin
               errors++;
               $display("[TB] FAIL fm_write: got idx=%0d data=%0h, expected idx=%0d data=%0h",
                        idx_fm, data_fm, e.idx, e.data);
            end
         end
      end
      if (we_n0) begin
         checks++;
         if (q_n0.size() == 0) begin
            errors++;
            $display("[TB] FAIL n0_write: got unexpected write idx=%0d data=%0h, expected none", idx_n0, data_n0);
         end else begin
            e = q_n0.pop_front();
            if ({4'b0, idx_n0} !== e.idx || data_n0 !== e.data) begin
               errors++;
               $display("[TB] FAIL n0_write: got idx=%0d data=%0h, expected idx=%0d data=%0h",
                        idx_n0, data_n0, e.idx, e.data);
            end
         end
      end
   end

   // Main directed sequence
   initial begin
      wr_t e;
      int  nonzero;
      rst = 1'b1; rst_aux = 1'b1;
      start = 1'b0; wr_en = 1'b0; wr_idx = '0; wr_data = '0;
      start_fm = 1'b0; wr_en_fm = 1'b0; wr_idx_fm = '0; wr_data_fm = '0;
      start_n0 = 1'b0; wr_en_n0 = 1'b0; wr_idx_n0 = '0; wr_data_n0 = '0;
      for (int i = 0; i < 32; i++) mem[i] = 32'hFFFF_FFFF;

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_we", {31'b0, we}, 32'h0);
      checkOutput("reset_idx", {27'b0, idx}, 32'h0);
      checkOutput("reset_data", data, 32'h0);
      checkOutput("reset_done_busy_ready", {29'b0, done, busy, ready}, 32'h2);

      // Expected sweeps for all three instances, then the client write held during FILL
      pushMainFill(32);
      for (int i = 0; i < 20; i++) begin
         e.idx = 5'(i); e.data = 32'(i);
         q_fm.push_back(e);
      end
      e.idx = 5'd0; e.data = 32'hA5A5_0001;
      q_n0.push_back(e);
      applyStimulus(1'b1, 5'd7, 32'h1234_5678, 1'b0, 1'b0);
      e.idx = 5'd7; e.data = 32'h1234_5678;
      q_main.push_back(e);

      rst = 1'b0; rst_aux = 1'b0;
      for (int k = 1; k <= 33; k++) begin
         @(posedge clk);
         #1;
         if (k <= 32) checkOutput("fill_flags", {29'b0, done, busy, ready}, 32'h2);
         else         checkOutput("done_flags", {29'b0, done, busy, ready}, 32'h5);
         if (k <= 20)      checkOutput("fm_fill_flags", {30'b0, done_fm, busy_fm}, 32'h1);
         else if (k == 21) checkOutput("fm_done_flags", {30'b0, done_fm, busy_fm}, 32'h2);
         if (k == 1) checkOutput("n0_fill_flags", {30'b0, done_n0, busy_n0}, 32'h1);
         if (k == 2) checkOutput("n0_done_flags", {30'b0, done_n0, busy_n0}, 32'h2);
      end

      // Held client write lands one cycle after DONE rose
      @(posedge clk);
      #1;
      checkOutput("held_write_we", {31'b0, we}, 32'h1);
      checkOutput("held_write_idx", {27'b0, idx}, 32'd7);

      // Back-to-back client writes to index 5
      applyStimulus(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      checkOutput("b2b_first_data", data, 32'hDEAD_BEEF);
      applyStimulus(1'b1, 5'd5, 32'h0000_0001, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      checkOutput("b2b_second_we", {31'b0, we}, 32'h1);
      checkOutput("b2b_second_data", data, 32'h1);
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      checkOutput("idle_we", {31'b0, we}, 32'h0);
      checkOutput("mem_idx5", mem[5], 32'h1);
      checkOutput("mem_idx7", mem[7], 32'h1234_5678);

      // START in RUN with a client write: not accepted; previous write still lands
      applyStimulus(1'b1, 5'd3, 32'h33, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      applyStimulus(1'b1, 5'd9, 32'hAAAA, 1'b1, 1'b0);
      pushMainFill(32);
      @(posedge clk);
      #1;
      checkOutput("restart_done_busy_we", {29'b0, done, busy, we}, 32'h2);
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
      for (int k = 1; k <= 33; k++) begin
         @(posedge clk);
         #1;
         if (k == 6) applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
         if (k == 7) applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
         if (k <= 32) checkOutput("refill_flags", {29'b0, done, busy, ready}, 32'h2);
         else         checkOutput("refill_done_flags", {29'b0, done, busy, ready}, 32'h5);
      end

      // Reset asserted while the sweep presents index 10
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
      pushMainFill(11);
      for (int k = 1; k <= 11; k++) begin
         @(posedge clk);
         #1;
         checkOutput("partial_sweep_idx", {27'b0, idx}, 32'(k - 1));
      end
      @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      checkOutput("async_rst_flags", {28'b0, we, done, busy, ready}, 32'h2);
      checkOutput("async_rst_idx", {27'b0, idx}, 32'h0);
      checkOutput("async_rst_data", data, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      pushMainFill(32);
      for (int k = 1; k <= 33; k++) begin
         @(posedge clk);
         #1;
         if (k == 1) checkOutput("post_rst_first_idx", {27'b0, idx}, 32'h0);
         if (k <= 32) checkOutput("post_rst_flags", {29'b0, done, busy, ready}, 32'h2);
         else         checkOutput("post_rst_done_flags", {29'b0, done, busy, ready}, 32'h5);
      end

      // Everything expected was seen and the model file holds the fill pattern
      repeat (2) @(posedge clk);
      #1;
      checkOutput("main_queue_empty", 32'(q_main.size()), 32'h0);
      checkOutput("fm_queue_empty", 32'(q_fm.size()), 32'h0);
      checkOutput("n0_queue_empty", 32'(q_n0.size()), 32'h0);
      nonzero = 0;
      for (int i = 0; i < 32; i++) begin
         if (mem[i] !== 32'h0) nonzero++;
      end
      checkOutput("mem_all_zero", 32'(nonzero), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
